// File: rtl/result_pipe.sv
// ---------------------------------------------------------------------------
// result_pipe
//
// Producer side of operand bypassing for the Beta pipeline. Carries
// execute-stage results through the MEM and WB pipeline registers, drives
// the register-file write port, publishes every bypass source used by the
// decode-stage operand muxes, runs the data-memory request handshake and
// raises the memory-wait hold and the load-use stall.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ex_*                     execute-stage instruction (valid, rc, y, pc,
//                            branch flag, ld, st, store data)
//   dec_ra, dec_rb           decode-stage source registers
//   rc_ex/rc_mem/rc_wb       bypass tags, 31 when the stage is empty
//   ex_/mem_ y,pc bypass     Y and PC bypass values per stage
//   op_br_or_jmp_ex/_mem     branch/JMP flag per stage
//   wb_bypass                WB-stage write value
//   rf_we, rf_wa, rf_wd      register-file write port
//   mem_req/we/addr/wdata    data-memory request
//   mem_ready, mem_rdata     memory accept / load data (same cycle)
//   hold_ex                  freeze execute and upstream (memory wait)
//   stall_dec                freeze decode, bubble into execute (load-use)
//
// Configuration
//   RESULT_PIPE_LD_INTERLOCK_EN  defined: load-use comparators drive
//                                stall_dec; undefined: stall_dec tied 0.
// ---------------------------------------------------------------------------
module result_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rc,
    input  logic [31:0] ex_y,
    input  logic [31:0] ex_pc,
    input  logic        ex_br_or_jmp,
    input  logic        ex_ld,
    input  logic        ex_st,
    input  logic [31:0] ex_st_data,
    input  logic [4:0]  dec_ra,
    input  logic [4:0]  dec_rb,
    output logic [4:0]  rc_ex,
    output logic [4:0]  rc_mem,
    output logic [4:0]  rc_wb,
    output logic [31:0] ex_y_bypass,
    output logic [31:0] ex_pc_bypass,
    output logic [31:0] mem_y_bypass,
    output logic [31:0] mem_pc_bypass,
    output logic        op_br_or_jmp_ex,
    output logic        op_br_or_jmp_mem,
    output logic [31:0] wb_bypass,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        hold_ex,
    output logic        stall_dec
);

    localparam logic [4:0] R31 = 5'd31;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_t;

    // MEM pipeline register
    logic        r_mem_valid;
    logic [4:0]  r_mem_rc;
    logic [31:0] r_mem_y;
    logic [31:0] r_mem_pc;
    logic        r_mem_br;
    logic        r_mem_ld;
    logic        r_mem_st;
    logic [31:0] r_mem_st_data;

    // WB pipeline register
    logic        r_wb_valid;
    logic [4:0]  r_wb_rc;
    logic [31:0] r_wb_value;

    mem_state_t  r_state;
    mem_state_t  w_next_state;

    logic        w_mem_op;
    logic        w_hold;
    logic [31:0] w_mem_result;

    assign w_mem_op = r_mem_valid & (r_mem_ld | r_mem_st);

    // A load's value is only known once mem_ready arrives, so it is picked
    // here for WB and never appears on the MEM-stage Y bypass.
    assign w_mem_result = r_mem_ld ? mem_rdata :
                          r_mem_br ? r_mem_pc  : r_mem_y;

    // ------------------------------------------------------------------
    // Memory handshake FSM: state register
    // ------------------------------------------------------------------
    // NOTE: reset is synchronous, so it only acts on a clock edge; every
    // pipeline flop, including the data fields, is cleared so the bypass
    // outputs read 0 after reset rather than stale values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MEM_IDLE;
        end else begin
            // NOTE: non-blocking assignments on all state so every flop
            // samples pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Memory handshake FSM: next state and request outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = r_mem_y;
        mem_wdata    = r_mem_st_data;
        case (r_state)
            MEM_IDLE: begin
                if (w_mem_op) begin
                    mem_req = 1'b1;
                    mem_we  = r_mem_st;
                    if (!mem_ready) begin
                        w_next_state = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                // The MEM register is frozen while waiting, so address and
                // data are stable by construction.
                mem_req = 1'b1;
                mem_we  = r_mem_st;
                if (mem_ready) begin
                    w_next_state = MEM_IDLE;
                end
            end
            default: w_next_state = MEM_IDLE;
        endcase
        w_hold = mem_req & ~mem_ready;
    end

    assign hold_ex = w_hold;

    // ------------------------------------------------------------------
    // MEM and WB pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_valid   <= 1'b0;
            r_mem_rc      <= R31;
            r_mem_y       <= '0;
            r_mem_pc      <= '0;
            r_mem_br      <= 1'b0;
            r_mem_ld      <= 1'b0;
            r_mem_st      <= 1'b0;
            r_mem_st_data <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_rc       <= R31;
            r_wb_value    <= '0;
        end else if (w_hold) begin
            // MEM keeps the waiting access; WB takes a bubble.
            r_wb_valid    <= 1'b0;
            r_wb_rc       <= R31;
        end else begin
            r_mem_valid   <= ex_valid;
            r_mem_rc      <= ex_rc;
            r_mem_y       <= ex_y;
            r_mem_pc      <= ex_pc;
            r_mem_br      <= ex_br_or_jmp;
            r_mem_ld      <= ex_ld;
            r_mem_st      <= ex_st;
            r_mem_st_data <= ex_st_data;
            r_wb_valid    <= r_mem_valid;
            r_wb_rc       <= r_mem_rc;
            r_wb_value    <= w_mem_result;
        end
    end

    // ------------------------------------------------------------------
    // Bypass sources and register-file port
    // ------------------------------------------------------------------
    assign rc_ex            = ex_valid ? ex_rc : R31;
    assign ex_y_bypass      = ex_y;
    assign ex_pc_bypass     = ex_pc;
    assign op_br_or_jmp_ex  = ex_valid & ex_br_or_jmp;

    assign rc_mem           = r_mem_valid ? r_mem_rc : R31;
    assign mem_y_bypass     = r_mem_y;
    assign mem_pc_bypass    = r_mem_pc;
    assign op_br_or_jmp_mem = r_mem_valid & r_mem_br;

    assign rc_wb            = r_wb_valid ? r_wb_rc : R31;
    assign wb_bypass        = r_wb_value;
    assign rf_we            = r_wb_valid & (r_wb_rc != R31);
    assign rf_wa            = r_wb_rc;
    assign rf_wd            = r_wb_value;

    // ------------------------------------------------------------------
    // Load-use interlock
    // ------------------------------------------------------------------
`ifdef RESULT_PIPE_LD_INTERLOCK_EN
    function automatic logic src_hit(input logic [4:0] src, input logic [4:0] tag);
        return (src != R31) && (src == tag);
    endfunction

    logic w_ex_ld_hit;
    logic w_mem_ld_hit;

    assign w_ex_ld_hit  = ex_valid & ex_ld &
                          (src_hit(dec_ra, ex_rc) | src_hit(dec_rb, ex_rc));
    assign w_mem_ld_hit = r_mem_valid & r_mem_ld &
                          (src_hit(dec_ra, r_mem_rc) | src_hit(dec_rb, r_mem_rc));
    assign stall_dec    = w_ex_ld_hit | w_mem_ld_hit;
`else
    logic w_unused_dec;
    assign w_unused_dec = ^{dec_ra, dec_rb};
    assign stall_dec    = 1'b0;
`endif

endmodule

// File: tb/tb_result_pipe.sv
// ---------------------------------------------------------------------------
// tb_result_pipe
//
// Self-checking bench for result_pipe. A table of per-cycle records gives
// the execute-stage instruction and memory response for that cycle plus the
// outputs expected in that same cycle; hand-written sequences cover memory
// wait, back-to-back loads, the load-use interlock and reset mid-wait.
// Expected stall_dec follows RESULT_PIPE_LD_INTERLOCK_EN.
// ---------------------------------------------------------------------------
module tb_result_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rc;
    logic [31:0] ex_y;
    logic [31:0] ex_pc;
    logic        ex_br_or_jmp;
    logic        ex_ld;
    logic        ex_st;
    logic [31:0] ex_st_data;
    logic [4:0]  dec_ra;
    logic [4:0]  dec_rb;
    logic [4:0]  rc_ex, rc_mem, rc_wb;
    logic [31:0] ex_y_bypass, ex_pc_bypass, mem_y_bypass, mem_pc_bypass;
    logic        op_br_or_jmp_ex, op_br_or_jmp_mem;
    logic [31:0] wb_bypass;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hold_ex, stall_dec;

`ifdef RESULT_PIPE_LD_INTERLOCK_EN
    localparam logic IL_EN = 1'b1;
`else
    localparam logic IL_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    result_pipe dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_rc(ex_rc), .ex_y(ex_y), .ex_pc(ex_pc),
        .ex_br_or_jmp(ex_br_or_jmp), .ex_ld(ex_ld), .ex_st(ex_st),
        .ex_st_data(ex_st_data), .dec_ra(dec_ra), .dec_rb(dec_rb),
        .rc_ex(rc_ex), .rc_mem(rc_mem), .rc_wb(rc_wb),
        .ex_y_bypass(ex_y_bypass), .ex_pc_bypass(ex_pc_bypass),
        .mem_y_bypass(mem_y_bypass), .mem_pc_bypass(mem_pc_bypass),
        .op_br_or_jmp_ex(op_br_or_jmp_ex), .op_br_or_jmp_mem(op_br_or_jmp_mem),
        .wb_bypass(wb_bypass), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hold_ex(hold_ex), .stall_dec(stall_dec)
    );

    typedef struct {
        // inputs for this cycle
        logic        v;
        logic [4:0]  rc;
        logic [31:0] y;
        logic [31:0] pc;
        logic        br;
        logic        ld;
        logic        st;
        logic [31:0] sd;
        logic        rdy;
        logic [31:0] rdata;
        // expected outputs in this cycle
        logic [4:0]  e_rc_mem;
        logic [4:0]  e_rc_wb;
        logic        e_we;
        logic [31:0] e_wd;
        logic        e_req;
        logic        e_mwe;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_hold;
        logic        e_brm;
        logic        chk_mem;
        logic [31:0] e_my;
        logic [31:0] e_mpc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rc, input logic [31:0] y,
                         input logic [31:0] pc, input logic br, input logic ld,
                         input logic st, input logic [31:0] sd,
                         input logic rdy, input logic [31:0] rdata);
        ex_valid     = v;
        ex_rc        = rc;
        ex_y         = y;
        ex_pc        = pc;
        ex_br_or_jmp = br;
        ex_ld        = ld;
        ex_st        = st;
        ex_st_data   = sd;
        mem_ready    = rdy;
        mem_rdata    = rdata;
    endtask

    task automatic bubble(input logic rdy, input logic [31:0] rdata);
        drive(1'b0, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, rdy, rdata);
    endtask

    // Advance one cycle: through the active edge to the next sampling point.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[16];

    initial begin
        // v rc y pc br ld st sd rdy rdata | rc_mem rc_wb we wd req mwe addr wdata hold brm chk my mpc
        vecs[0]  = '{1, 3,  32'h10,  32'h4,   0, 0, 0, 0,     0, 0,           31, 31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[1]  = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           3,  31, 0, 0,           0, 0, 0,       0,     0, 0, 1, 32'h10,  32'h4};
        vecs[2]  = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           31, 3,  1, 32'h10,      0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[3]  = '{1, 28, 32'h999, 32'h104, 1, 0, 0, 0,     0, 0,           31, 31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[4]  = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           28, 31, 0, 0,           0, 0, 0,       0,     0, 1, 1, 32'h999, 32'h104};
        vecs[5]  = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           31, 28, 1, 32'h104,     0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[6]  = '{1, 31, 32'h40,  32'h20,  0, 0, 1, 32'h77, 0, 0,          31, 31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[7]  = '{0, 31, 0,       0,       0, 0, 0, 0,     1, 0,           31, 31, 0, 0,           1, 1, 32'h40,  32'h77, 0, 0, 1, 32'h40,  32'h20};
        vecs[8]  = '{0, 31, 0,       0,       0, 0, 0, 0,     1, 0,           31, 31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[9]  = '{1, 1,  32'h1,   32'h30,  0, 0, 0, 0,     0, 0,           31, 31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[10] = '{1, 2,  32'h2,   32'h34,  0, 0, 0, 0,     0, 0,           1,  31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[11] = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           2,  1,  1, 32'h1,       0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[12] = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           31, 2,  1, 32'h2,       0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[13] = '{1, 6,  32'h300, 32'h40,  0, 1, 0, 0,     0, 0,           31, 31, 0, 0,           0, 0, 0,       0,     0, 0, 0, 0,       0};
        vecs[14] = '{0, 31, 0,       0,       0, 0, 0, 0,     1, 32'hCAFE0006, 6, 31, 0, 0,           1, 0, 32'h300, 0,     0, 0, 0, 0,       0};
        vecs[15] = '{0, 31, 0,       0,       0, 0, 0, 0,     0, 0,           31, 6,  1, 32'hCAFE0006, 0, 0, 0,      0,     0, 0, 0, 0,       0};

        // ---------------- reset with a live load in execute ----------------
        rst    = 1'b1;
        dec_ra = 5'd31;
        dec_rb = 5'd31;
        drive(1'b1, 5'd5, 32'h100, 32'h8, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        step();
        check("rst rc_mem", rc_mem, 31);
        check("rst rc_wb", rc_wb, 31);
        check("rst rf_we", rf_we, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst hold_ex", hold_ex, 0);
        check("rst op_br_mem", op_br_or_jmp_mem, 0);
        check("rst mem_y", mem_y_bypass, 0);
        check("rst mem_pc", mem_pc_bypass, 0);
        check("rst wb_bypass", wb_bypass, 0);
        step();
        check("rst2 rc_mem", rc_mem, 31);
        check("rst2 mem_req", mem_req, 0);
        rst = 1'b0;
        bubble(1'b0, 32'h0);
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].rc, vecs[i].y, vecs[i].pc, vecs[i].br,
                  vecs[i].ld, vecs[i].st, vecs[i].sd, vecs[i].rdy, vecs[i].rdata);
            #1;
            check($sformatf("v%0d rc_ex", i), rc_ex, vecs[i].v ? vecs[i].rc : 5'd31);
            check($sformatf("v%0d rc_mem", i), rc_mem, vecs[i].e_rc_mem);
            check($sformatf("v%0d rc_wb", i), rc_wb, vecs[i].e_rc_wb);
            check($sformatf("v%0d rf_we", i), rf_we, vecs[i].e_we);
            check($sformatf("v%0d mem_req", i), mem_req, vecs[i].e_req);
            check($sformatf("v%0d hold_ex", i), hold_ex, vecs[i].e_hold);
            check($sformatf("v%0d op_br_mem", i), op_br_or_jmp_mem, vecs[i].e_brm);
            if (vecs[i].e_we) begin
                check($sformatf("v%0d rf_wa", i), rf_wa, vecs[i].e_rc_wb);
                check($sformatf("v%0d rf_wd", i), rf_wd, vecs[i].e_wd);
                check($sformatf("v%0d wb_bypass", i), wb_bypass, vecs[i].e_wd);
            end
            if (vecs[i].e_req) begin
                check($sformatf("v%0d mem_we", i), mem_we, vecs[i].e_mwe);
                check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                if (vecs[i].e_mwe)
                    check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            if (vecs[i].chk_mem) begin
                check($sformatf("v%0d mem_y", i), mem_y_bypass, vecs[i].e_my);
                check($sformatf("v%0d mem_pc", i), mem_pc_bypass, vecs[i].e_mpc);
            end
            step();
        end

        // ---------------- LD R5 @0x200 with three wait cycles ----------------
        drive(1'b1, 5'd5, 32'h200, 32'h50, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        dec_ra = 5'd31;
        #1;
        check("ld ex stall ra31", stall_dec, 0);
        check("ld ex_y_bypass", ex_y_bypass, 32'h200);
        dec_ra = 5'd5;
        #1;
        check("ld ex stall ra5", stall_dec, IL_EN);
        step();
        for (int i = 0; i < 3; i++) begin
            bubble(1'b0, 32'h0);
            dec_ra = 5'd31;
            dec_rb = 5'd5;
            #1;
            check($sformatf("wait%0d mem_req", i), mem_req, 1);
            check($sformatf("wait%0d mem_addr", i), mem_addr, 32'h200);
            check($sformatf("wait%0d mem_we", i), mem_we, 0);
            check($sformatf("wait%0d hold_ex", i), hold_ex, 1);
            check($sformatf("wait%0d rc_wb", i), rc_wb, 31);
            check($sformatf("wait%0d stall_dec", i), stall_dec, IL_EN);
            step();
        end
        bubble(1'b1, 32'hDEADBEEF);
        #1;
        check("ready mem_req", mem_req, 1);
        check("ready mem_addr", mem_addr, 32'h200);
        check("ready hold_ex", hold_ex, 0);
        check("ready stall_dec", stall_dec, IL_EN);
        step();
        bubble(1'b0, 32'h0);
        #1;
        check("ldwb mem_req", mem_req, 0);
        check("ldwb hold_ex", hold_ex, 0);
        check("ldwb stall_dec", stall_dec, 0);
        check("ldwb rf_we", rf_we, 1);
        check("ldwb rf_wa", rf_wa, 5);
        check("ldwb rf_wd", rf_wd, 32'hDEADBEEF);
        dec_rb = 5'd31;
        step();

        // ---------------- back-to-back loads ----------------
        drive(1'b1, 5'd8, 32'h10, 32'h60, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        drive(1'b1, 5'd9, 32'h20, 32'h64, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("b2b c1 mem_addr", mem_addr, 32'h10);
        check("b2b c1 hold_ex", hold_ex, 1);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'h88;
        #1;
        check("b2b c2 rc_mem", rc_mem, 8);
        check("b2b c2 mem_addr", mem_addr, 32'h10);
        check("b2b c2 hold_ex", hold_ex, 0);
        check("b2b c2 rc_wb", rc_wb, 31);
        step();
        bubble(1'b1, 32'h99);
        #1;
        check("b2b c3 rc_mem", rc_mem, 9);
        check("b2b c3 mem_req", mem_req, 1);
        check("b2b c3 mem_addr", mem_addr, 32'h20);
        check("b2b c3 rc_wb", rc_wb, 8);
        check("b2b c3 rf_wd", rf_wd, 32'h88);
        step();
        bubble(1'b0, 32'h0);
        #1;
        check("b2b c4 rc_wb", rc_wb, 9);
        check("b2b c4 rf_wd", rf_wd, 32'h99);
        check("b2b c4 mem_req", mem_req, 0);
        step();

        // ---------------- reset during a memory wait ----------------
        drive(1'b1, 5'd4, 32'h50, 32'h70, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        bubble(1'b0, 32'h0);
        #1;
        check("rstw hold_ex", hold_ex, 1);
        rst = 1'b1;
        step();
        check("rstw mem_req", mem_req, 0);
        check("rstw hold_ex after", hold_ex, 0);
        check("rstw rc_mem", rc_mem, 31);
        check("rstw rf_we", rf_we, 0);
        rst = 1'b0;
        step();
        check("rstw idle mem_req", mem_req, 0);
        check("rstw idle rc_wb", rc_wb, 31);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
